// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Main control unit of the multicycle RV32I core. Walks every instruction
//   through fetch / decode / execute / memory / writeback. It drives the
//   datapath selects, the write enables and the alu_op code that goes to the
//   ALU control decoder.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (state -> FETCH, illegal_o -> 0)
//   opcode[6:0]   instr[6:0] from the instruction register, stable from DECODE on
//   mem_ready     memory completes the current access this cycle
//   branch_taken  ALU branch comparison result, valid in BRANCH
//   alu_op[1:0]   00 MEM, 01 BRANCH, 10 RTYPE, 11 ITYPE
//   alu_src_a     00 PC, 01 OldPC, 10 rs1, 11 zero
//   alu_src_b     00 rs2, 01 imm, 10 const 4
//   result_src    00 ALUOut, 01 MemData, 10 ALUResult
//   adr_src       0 PC, 1 ALUOut as memory address
//   ir_write      load instruction register (and OldPC)
//   pc_write      PC <= Result
//   mem_write     store strobe
//   reg_write     register file write enable
//   state_o[3:0]  current state code
//   illegal_o     sticky illegal-opcode flag
//
// Configuration
//   ILLEGAL_TRAP_EN  defined: an unknown opcode in DECODE enters ERROR (code 14)
//                    and sets illegal_o; both hold until reset.
//                    undefined: an unknown opcode is a NOP back to FETCH,
//                    illegal_o is tied 0 and ERROR is not built.

module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
`ifdef ILLEGAL_TRAP_EN
    S_UPPER    = 4'd13,
    S_ERROR    = 4'd14
`else
    S_UPPER    = 4'd13
`endif
  } state_t;

  state_t state;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_ITYPE:          state <= S_EXECI;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALR;
            OP_LUI, OP_AUIPC:  state <= S_UPPER;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state     <= S_ERROR;
              illegal_q <= 1'b1;
`else
              state     <= S_FETCH;
`endif
            end
          endcase
        end
        S_MEMADR:   state <= (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_JALR:     state <= S_LINK;
        S_LINK:     state <= S_ALUWB;
        S_UPPER:    state <= S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
        S_ERROR:    state <= S_ERROR;
`endif
        // Unused codes recover to FETCH.
        default:    state <= S_FETCH;
      endcase
    end
  end

  assign state_o = state;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  logic pc_update;
  logic branch;
  logic ir_write_c;
  logic mem_write_c;
  logic reg_write_c;

  always_comb begin
    alu_op      = '0;
    alu_src_a   = '0;
    alu_src_b   = '0;
    result_src  = '0;
    adr_src     = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_c = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      S_ALUWB:    reg_write_c = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        pc_update = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      S_LINK: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_UPPER: begin
        alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
      end
      default: ;
    endcase
  end

  // Enables are masked by rst_n so that FETCH's mem_ready-driven writes
  // cannot fire while reset is held.
  assign ir_write  = rst_n & ir_write_c;
  assign pc_write  = rst_n & (pc_update | (branch & branch_taken));
  assign mem_write = rst_n & mem_write_c;
  assign reg_write = rst_n & reg_write_c;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
  logic       adr_src, ir_write, pc_write, mem_write, reg_write;
  logic [3:0] state_o;
  logic       illegal_o;

  multicycle_control_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .alu_op       (alu_op),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .result_src   (result_src),
    .adr_src      (adr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .state_o      (state_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk = ~clk;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
  endtask

  // ---------------- reference model ----------------
  // The model keeps the current state code plus a queue of the state codes
  // still to be visited by the current instruction; the queue is planned
  // once, in DECODE, from the opcode class.
  int exp_state;
  int plan[$];
  bit exp_ill;

  function automatic void model_reset();
    exp_state = 0;
    plan.delete();
    exp_ill = 1'b0;
  endfunction

  function automatic int next_planned();
    if (plan.size() == 0) return 0;
    return plan.pop_front();
  endfunction

  function automatic void model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (exp_state)
      0: if (mem_ready) exp_state = 1;
      1: begin
        case (opcode)
          7'b0000011: plan = '{2, 3, 4};
          7'b0100011: plan = '{2, 5};
          7'b0110011: plan = '{6, 8};
          7'b0010011: plan = '{7, 8};
          7'b1100011: plan = '{9};
          7'b1101111: plan = '{10, 8};
          7'b1100111: plan = '{11, 12, 8};
          7'b0110111,
          7'b0010111: plan = '{13, 8};
          default: begin
            plan.delete();
            if (TRAP) begin
              plan.push_back(14);
              exp_ill = 1'b1;
            end
          end
        endcase
        exp_state = next_planned();
      end
      14: exp_state = 14;
      default: begin
        if (!((exp_state == 3 || exp_state == 5) && !mem_ready))
          exp_state = next_planned();
      end
    endcase
  endfunction

  typedef struct packed {
    logic [1:0] alu_op, a, b, rs;
    logic       adr, irw, pcw, mw, rw;
  } outs_t;

  function automatic outs_t model_outs(int st, logic mr, logic bt, logic [6:0] op, logic rn);
    outs_t o;
    logic pcu, br;
    o = '0; pcu = 1'b0; br = 1'b0;
    case (st)
      0:  begin o.b = 2'b10; o.rs = 2'b10; o.irw = mr; pcu = mr; end
      1:  begin o.a = 2'b01; o.b = 2'b01; end
      2:  begin o.a = 2'b10; o.b = 2'b01; end
      3:  o.adr = 1'b1;
      4:  begin o.rs = 2'b01; o.rw = 1'b1; end
      5:  begin o.adr = 1'b1; o.mw = 1'b1; end
      6:  begin o.a = 2'b10; o.alu_op = 2'b10; end
      7:  begin o.a = 2'b10; o.b = 2'b01; o.alu_op = 2'b11; end
      8:  o.rw = 1'b1;
      9:  begin o.a = 2'b10; o.alu_op = 2'b01; br = 1'b1; end
      10: begin o.a = 2'b01; o.b = 2'b10; pcu = 1'b1; end
      11: begin o.a = 2'b10; o.b = 2'b01; o.rs = 2'b10; pcu = 1'b1; end
      12: begin o.a = 2'b01; o.b = 2'b10; end
      13: begin o.a = (op == 7'b0110111) ? 2'b11 : 2'b01; o.b = 2'b01; end
      default: ;
    endcase
    o.pcw = pcu | (br & bt);
    if (!rn) begin o.irw = 1'b0; o.pcw = 1'b0; o.mw = 1'b0; o.rw = 1'b0; end
    return o;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      outs_t e;
      e = model_outs(exp_state, mem_ready, branch_taken, opcode, rst_n);
      chk("state_o",    state_o,    exp_state);
      chk("illegal_o",  illegal_o,  exp_ill);
      chk("alu_op",     alu_op,     e.alu_op);
      chk("alu_src_a",  alu_src_a,  e.a);
      chk("alu_src_b",  alu_src_b,  e.b);
      chk("result_src", result_src, e.rs);
      chk("adr_src",    adr_src,    e.adr);
      chk("ir_write",   ir_write,   e.irw);
      chk("pc_write",   pc_write,   e.pcw);
      chk("mem_write",  mem_write,  e.mw);
      chk("reg_write",  reg_write,  e.rw);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Literal pin of both DUT and model state.
  task automatic at(input int code);
    chk("dir_state", state_o, code);
    chk("model_state", exp_state, code);
  endtask

  // Called at posedge+1: asserts reset mid-cycle and checks the immediate effect.
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_enables", {ir_write, pc_write, mem_write, reg_write}, 0);
  endtask

  task automatic release_reset();
    tick();
    rst_n = 1'b1;
  endtask

  logic [6:0] legal_ops [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int trap_cnt;
    legal_ops[0] = 7'b0000011; legal_ops[1] = 7'b0100011; legal_ops[2] = 7'b0110011;
    legal_ops[3] = 7'b0010011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b1101111;
    legal_ops[6] = 7'b1100111; legal_ops[7] = 7'b0110111; legal_ops[8] = 7'b0010111;

    rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0;
    model_reset();
    tick(); tick();
    chk_en = 1'b1;
    at(0);
    chk("reset_illegal", illegal_o, 0);
    // mem_ready high while reset is held must not open any write enable
    mem_ready = 1'b1;
    #1;
    chk("reset_ir_write", ir_write, 0);
    chk("reset_pc_write", pc_write, 0);
    release_reset();

    // R-type: 0,1,6,8,0
    opcode = 7'b0110011;
    tick(); at(1);
    tick(); at(6); chk("rtype_alu_op", alu_op, 2);
    tick(); at(8); chk("rtype_reg_write", reg_write, 1);
    tick(); at(0);

    // Load with 3 stall cycles in MEMREAD
    opcode = 7'b0000011;
    tick(); at(1);
    tick(); at(2);
    tick(); at(3);
    mem_ready = 1'b0;
    tick(); at(3);
    tick(); at(3);
    tick(); at(3);
    mem_ready = 1'b1;
    tick(); at(4); chk("load_result_src", result_src, 1);
    tick(); at(0);

    // Store
    opcode = 7'b0100011;
    tick(); at(1);
    tick(); at(2);
    tick(); at(5); chk("store_mem_write", mem_write, 1);
    tick(); at(0);

    // Branch not taken, then taken
    opcode = 7'b1100011; branch_taken = 1'b0;
    tick(); at(1);
    tick(); at(9);
    chk("br_nt_pc_write", pc_write, 0); chk("br_alu_op", alu_op, 1);
    tick(); at(0);
    branch_taken = 1'b1;
    tick(); at(1);
    tick(); at(9); chk("br_t_pc_write", pc_write, 1);
    tick(); at(0);
    branch_taken = 1'b0;

    // JALR: 0,1,11,12,8,0
    opcode = 7'b1100111;
    tick(); at(1);
    tick(); at(11); chk("jalr_pc_write", pc_write, 1);
    tick(); at(12);
    tick(); at(8);  chk("jalr_reg_write", reg_write, 1);
    tick(); at(0);  chk("fetch_pc_write", pc_write, 1);

    // LUI selects zero as operand A
    opcode = 7'b0110111;
    tick(); at(1);
    tick(); at(13); chk("lui_src_a", alu_src_a, 3);
    tick(); at(8);
    tick(); at(0);

    // Illegal opcode
    opcode = 7'b0000000;
    tick(); at(1);
    tick();
    if (TRAP) begin
      at(14); chk("trap_illegal", illegal_o, 1);
      tick(); tick(); tick();
      at(14); chk("trap_illegal_held", illegal_o, 1);
      async_reset();
      release_reset();
    end else begin
      at(0); chk("nop_illegal", illegal_o, 0);
    end

    // Reset while stalled in MEMREAD
    mem_ready = 1'b1;
    opcode = 7'b0000011;
    while (exp_state != 0) tick();
    tick(); tick(); tick(); at(3);
    mem_ready = 1'b0;
    tick(); at(3);
    async_reset();
    mem_ready = 1'b1;
    #1;
    chk("rst_memread_ir_write", ir_write, 0);
    release_reset();

    // Randomised traffic
    trap_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (exp_state == 0) begin
        if ($urandom_range(0, 7) == 0) opcode = 7'($urandom_range(0, 127));
        else opcode = legal_ops[$urandom_range(0, 8)];
      end
      mem_ready    = ($urandom_range(0, 3) != 0);
      branch_taken = 1'($urandom_range(0, 1));
      if (exp_state == 14) trap_cnt++;
      if (trap_cnt > 4 || $urandom_range(0, 299) == 0) begin
        trap_cnt = 0;
        async_reset();
        release_reset();
      end else begin
        tick();
      end
    end

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
